// File: rtl/magnetron_ctrl.sv
// Microwave magnetron controller: button edge detection, cook/pause/done state machine
// and a power-level PWM that gates the magnetron while the door is closed.
module magnetron_ctrl #(
  parameter int PWR_W    = 3,
  parameter int DONE_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_n,
  input  logic             stop_n,
  input  logic             clear_n,
  input  logic             closed_door,
  input  logic             finished_time,
  input  logic [PWR_W-1:0] power_level,
  output logic             magnetron,
  output logic             timer_run,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COOKING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(DONE_CYC - 1);

  state_t           st;
  logic             start_q, stop_q, clear_q;
  logic             armed;
  logic [PWR_W-1:0] pwr_q;
  logic [PWR_W-1:0] pwm_cnt;
  logic [7:0]       hold_cnt;
  logic             start_p, stop_p, clear_p;

  // armed blocks press recognition on the first edge after reset release
  assign start_p = armed & start_q & ~start_n;
  assign stop_p  = armed & stop_q  & ~stop_n;
  assign clear_p = armed & clear_q & ~clear_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      start_q  <= 1'b1;
      stop_q   <= 1'b1;
      clear_q  <= 1'b1;
      armed    <= 1'b0;
      pwr_q    <= '0;
      pwm_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      armed   <= 1'b1;
      start_q <= start_n;
      stop_q  <= stop_n;
      clear_q <= clear_n;
      case (st)
        IDLE: begin
          if (start_p && closed_door) begin
            st      <= COOKING;
            pwr_q   <= power_level;
            pwm_cnt <= '0;
          end
        end
        COOKING: begin
          pwm_cnt <= pwm_cnt + PWR_W'(1);
          if (clear_p) begin
            st <= IDLE;
          end else if (!closed_door || stop_p) begin
            st <= PAUSED;
          end else if (finished_time) begin
            st       <= DONE;
            hold_cnt <= '0;
          end
        end
        PAUSED: begin
          if (clear_p || stop_p) begin
            st <= IDLE;
          end else if (start_p && closed_door) begin
            st      <= COOKING;
            pwm_cnt <= '0;
          end
        end
        DONE: begin
          if (start_p || stop_p || clear_p || !closed_door || hold_cnt == HOLD_LAST) begin
            st <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Door gating is combinational so the magnetron drops in the cycle the door opens
  assign magnetron = (st == COOKING) && closed_door && ((&pwr_q) || (pwm_cnt < pwr_q));
  assign timer_run = (st == COOKING);
  assign done      = (st == DONE);
  assign state     = st;

endmodule

// File: tb/tb_magnetron_ctrl.sv
// Scoreboard bench for magnetron_ctrl: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_magnetron_ctrl;

  localparam logic [1:0] I = 2'd0;
  localparam logic [1:0] C = 2'd1;
  localparam logic [1:0] P = 2'd2;
  localparam logic [1:0] D = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n, start_n, stop_n, clear_n, closed_door, finished_time;
  logic [2:0] power_level;
  logic       magnetron, timer_run, done;
  logic [1:0] state;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       mag;
    logic       tr;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  magnetron_ctrl #(.PWR_W(3), .DONE_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_n(start_n), .stop_n(stop_n), .clear_n(clear_n),
    .closed_door(closed_door), .finished_time(finished_time), .power_level(power_level),
    .magnetron(magnetron), .timer_run(timer_run), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic exp_mag(input int lvl, input int cnt);
    return (lvl == 7) || (cnt < lvl);
  endfunction

  task automatic check_output(input exp_t e);
    logic [4:0] got, want;
    got  = {state, magnetron, timer_run, done};
    want = {e.st, e.mag, e.tr, e.dn};
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s: got state=%0d mag=%b tr=%b done=%b, expected state=%0d mag=%b tr=%b done=%b",
                  e.name, state, magnetron, timer_run, done, e.st, e.mag, e.tr, e.dn);
  endtask

  // Monitor: compares one expectation per cycle, mid-cycle away from the active edge
  always @(negedge clk) begin
    if (sb.size() > 0) check_output(sb.pop_front());
  end

  // Queue the expected outputs for the current cycle, then move to the next cycle
  task automatic apply_stimulus(input string name, input logic [1:0] st, input logic mag,
                                input logic tr, input logic dn);
    exp_t e;
    e.name = name; e.st = st; e.mag = mag; e.tr = tr; e.dn = dn;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start_n = 1'b1; stop_n = 1'b1; clear_n = 1'b1;
    closed_door = 1'b1; finished_time = 1'b0; power_level = 3'd0;
    @(posedge clk); #1;
    apply_stimulus("reset", I, 0, 0, 0);
    apply_stimulus("reset", I, 0, 0, 0);
    rst_n = 1'b1;
    apply_stimulus("post_reset", I, 0, 0, 0);
    apply_stimulus("post_reset", I, 0, 0, 0);

    // Level 3 PWM, power_level change while cooking, pause/resume, double stop
    power_level = 3'd3; start_n = 1'b0;
    apply_stimulus("a_press", I, 0, 0, 0);
    start_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) power_level = 3'd6;
      apply_stimulus($sformatf("a_pwm%0d", i), C, exp_mag(3, i % 8), 1, 0);
    end
    stop_n = 1'b0;
    apply_stimulus("a_stop", C, 1, 1, 0);
    stop_n = 1'b1; finished_time = 1'b1;
    apply_stimulus("a_paused_ft", P, 0, 0, 0);
    finished_time = 1'b0; start_n = 1'b0;
    apply_stimulus("a_resume_press", P, 0, 0, 0);
    start_n = 1'b1;
    for (int i = 0; i < 4; i++)
      apply_stimulus($sformatf("a_resume%0d", i), C, exp_mag(3, i), 1, 0);
    stop_n = 1'b0;
    apply_stimulus("a_stop2", C, 0, 1, 0);
    stop_n = 1'b1;
    apply_stimulus("a_paused2", P, 0, 0, 0);
    stop_n = 1'b0;
    apply_stimulus("a_stop3", P, 0, 0, 0);
    stop_n = 1'b1;
    apply_stimulus("a_cancel", I, 0, 0, 0);

    // Door open: start ignored in IDLE; level 7 cooking, door drop and resume
    closed_door = 1'b0; start_n = 1'b0;
    apply_stimulus("b_open_start", I, 0, 0, 0);
    start_n = 1'b1; closed_door = 1'b1;
    apply_stimulus("b_ignored", I, 0, 0, 0);
    power_level = 3'd7; start_n = 1'b0;
    apply_stimulus("b_press", I, 0, 0, 0);
    start_n = 1'b1;
    for (int i = 0; i < 4; i++) apply_stimulus("b_full", C, 1, 1, 0);
    closed_door = 1'b0;
    apply_stimulus("b_door_open", C, 0, 1, 0);
    apply_stimulus("b_paused", P, 0, 0, 0);
    closed_door = 1'b1;
    apply_stimulus("b_door_closed", P, 0, 0, 0);
    start_n = 1'b0;
    apply_stimulus("b_resume_press", P, 0, 0, 0);
    start_n = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus("b_resumed", C, 1, 1, 0);
    clear_n = 1'b0;
    apply_stimulus("b_clear", C, 1, 1, 0);
    clear_n = 1'b1;
    apply_stimulus("b_idle", I, 0, 0, 0);

    // start_n held low: one entry only, no resume from PAUSED while still held
    power_level = 3'd2; start_n = 1'b0;
    apply_stimulus("c_press", I, 0, 0, 0);
    for (int i = 1; i < 10; i++)
      apply_stimulus($sformatf("c_cook%0d", i), C, exp_mag(2, (i - 1) % 8), 1, 0);
    stop_n = 1'b0;
    apply_stimulus("c_stop", C, 1, 1, 0);
    stop_n = 1'b1;
    for (int i = 11; i < 20; i++) apply_stimulus($sformatf("c_held%0d", i), P, 0, 0, 0);
    start_n = 1'b1;
    apply_stimulus("c_release", P, 0, 0, 0);
    stop_n = 1'b0;
    apply_stimulus("c_stop2", P, 0, 0, 0);
    stop_n = 1'b1;
    apply_stimulus("c_idle", I, 0, 0, 0);

    // DONE hold for 8 cycles, then early exit on a start press
    power_level = 3'd7; start_n = 1'b0;
    apply_stimulus("d_press", I, 0, 0, 0);
    start_n = 1'b1;
    apply_stimulus("d_cook", C, 1, 1, 0);
    apply_stimulus("d_cook", C, 1, 1, 0);
    finished_time = 1'b1;
    apply_stimulus("d_finish", C, 1, 1, 0);
    finished_time = 1'b0;
    for (int i = 0; i < 8; i++) apply_stimulus($sformatf("d_done%0d", i), D, 0, 0, 1);
    apply_stimulus("d_auto_idle", I, 0, 0, 0);
    start_n = 1'b0;
    apply_stimulus("d_press2", I, 0, 0, 0);
    start_n = 1'b1;
    apply_stimulus("d_cook2", C, 1, 1, 0);
    finished_time = 1'b1;
    apply_stimulus("d_finish2", C, 1, 1, 0);
    finished_time = 1'b0;
    apply_stimulus("d_done_c1", D, 0, 0, 1);
    apply_stimulus("d_done_c2", D, 0, 0, 1);
    start_n = 1'b0;
    apply_stimulus("d_done_c3", D, 0, 0, 1);
    start_n = 1'b1;
    apply_stimulus("d_early_idle", I, 0, 0, 0);

    // Same-cycle event priority
    start_n = 1'b0;
    apply_stimulus("e_press", I, 0, 0, 0);
    start_n = 1'b1;
    apply_stimulus("e_cook", C, 1, 1, 0);
    clear_n = 1'b0; closed_door = 1'b0; finished_time = 1'b1;
    apply_stimulus("e_clear_door_ft", C, 0, 1, 0);
    clear_n = 1'b1; closed_door = 1'b1; finished_time = 1'b0;
    apply_stimulus("e_clear_wins", I, 0, 0, 0);
    start_n = 1'b0;
    apply_stimulus("e_press2", I, 0, 0, 0);
    start_n = 1'b1;
    apply_stimulus("e_cook2", C, 1, 1, 0);
    stop_n = 1'b0; finished_time = 1'b1;
    apply_stimulus("e_stop_ft", C, 1, 1, 0);
    stop_n = 1'b1; finished_time = 1'b0;
    apply_stimulus("e_stop_wins", P, 0, 0, 0);
    start_n = 1'b0;
    apply_stimulus("e_resume", P, 0, 0, 0);
    start_n = 1'b1;
    closed_door = 1'b0; finished_time = 1'b1;
    apply_stimulus("e_door_ft", C, 0, 1, 0);
    closed_door = 1'b1; finished_time = 1'b0;
    apply_stimulus("e_door_wins", P, 0, 0, 0);
    clear_n = 1'b0;
    apply_stimulus("e_clear_paused", P, 0, 0, 0);
    clear_n = 1'b1;
    apply_stimulus("e_idle", I, 0, 0, 0);

    // Asynchronous reset mid-cook, press gating after release, level 0 cooking
    power_level = 3'd5; start_n = 1'b0;
    apply_stimulus("f_press", I, 0, 0, 0);
    start_n = 1'b1;
    apply_stimulus("f_cook", C, 1, 1, 0);
    apply_stimulus("f_cook", C, 1, 1, 0);
    rst_n = 1'b0; power_level = 3'd0;
    apply_stimulus("f_async_reset", I, 0, 0, 0);
    rst_n = 1'b1; start_n = 1'b0;
    apply_stimulus("f_release_press", I, 0, 0, 0);
    apply_stimulus("f_held_ignored", I, 0, 0, 0);
    start_n = 1'b1;
    apply_stimulus("f_released", I, 0, 0, 0);
    start_n = 1'b0;
    apply_stimulus("f_press2", I, 0, 0, 0);
    start_n = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus("f_level0", C, 0, 1, 0);
    clear_n = 1'b0;
    apply_stimulus("f_clear", C, 0, 1, 0);
    clear_n = 1'b1;
    apply_stimulus("f_idle", I, 0, 0, 0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
